// File: rtl/pipeline_pkg.sv
// Shared types and constants for inter-stage pipeline barriers.
// Holds the barrier state encoding, occupancy codes and default stage widths.
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } barrier_state_e;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam int ID_EX_DATA_WIDTH = 64;
    localparam int ID_EX_CTRL_WIDTH = 3;

    function automatic logic [1:0] occ_of(barrier_state_e st);
        case (st)
            BUSY:    return OCC_ONE;
            FULL:    return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_entry_reg.sv
// Purpose: one held pipeline entry (payload + control) with load, clear and control-only clear.
// Latency: loaded value visible the cycle after load_i.
// Backpressure: none; the owner decides when to load.
module pipeline_entry_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  clr_i,
    input  logic                  ctrl_clr_i,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CTRL_WIDTH-1:0] ctrl_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;

    // A control-only clear blocks any load so a squashed entry keeps its old payload.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (ctrl_clr_i) begin
            ctrl_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipeline_skid_barrier.sv
// Purpose: inter-stage register with valid/ready handshake, 2-entry skid, flush and stall counter.
// Latency: 1 cycle in to out; full throughput while outReady=1.
// Backpressure: inReady drops only when both entries are held; it never depends on outReady.
module pipeline_skid_barrier
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH  = ID_EX_DATA_WIDTH,
    parameter int CTRL_WIDTH  = ID_EX_CTRL_WIDTH,
    parameter int COUNT_WIDTH = 16,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [DATA_WIDTH-1:0]  inData,
    input  logic [CTRL_WIDTH-1:0]  inCtrl,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  outData,
    output logic [CTRL_WIDTH-1:0]  outCtrl,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] stallCount
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    barrier_state_e state_q, state_d;

    logic                   in_fire, out_fire;
    logic                   main_load, skid_load, main_from_skid;
    logic [DATA_WIDTH-1:0]  main_data, skid_data, main_data_in;
    logic [CTRL_WIDTH-1:0]  main_ctrl, skid_ctrl, main_ctrl_in;
    logic [COUNT_WIDTH-1:0] stall_q, stall_d;

    assign inReady  = rst_n & (state_q != FULL);
    assign outValid = (state_q != EMPTY);
    assign in_fire  = inValid & inReady;
    assign out_fire = outValid & outReady;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = BUSY;
                    main_load = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && !out_fire) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (out_fire && !in_fire) begin
                    state_d = EMPTY;
                end else if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash overrides every transition and drops any same-cycle accept.
        if (flush) begin
            state_d        = EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign main_data_in = main_from_skid ? skid_data : inData;
    assign main_ctrl_in = main_from_skid ? skid_ctrl : inCtrl;

    pipeline_entry_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_main (
        .clk        (clk),
        .clr_i      (!rst_n),
        .ctrl_clr_i (flush),
        .load_i     (main_load),
        .data_i     (main_data_in),
        .ctrl_i     (main_ctrl_in),
        .data_o     (main_data),
        .ctrl_o     (main_ctrl)
    );

    pipeline_entry_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_skid (
        .clk        (clk),
        .clr_i      (!rst_n),
        .ctrl_clr_i (flush),
        .load_i     (skid_load),
        .data_i     (inData),
        .ctrl_i     (inCtrl),
        .data_o     (skid_data),
        .ctrl_o     (skid_ctrl)
    );

    always_comb begin
        stall_d = stall_q;
        if (outValid && !outReady && !flush && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign outData    = main_data;
    assign outCtrl    = ((ZERO_BUBBLE != 0) && !outValid) ? '0 : main_ctrl;
    assign occupancy  = occ_of(state_q);
    assign stallCount = stall_q;

endmodule

// File: tb/tb_pipeline_skid_barrier.sv
// Directed bench for pipeline_skid_barrier with a 4-bit stall counter to reach saturation quickly.
module tb_pipeline_skid_barrier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [63:0] inData;
    logic [2:0]  inCtrl;
    logic        outValid;
    logic        outReady;
    logic [63:0] outData;
    logic [2:0]  outCtrl;
    logic [1:0]  occupancy;
    logic [3:0]  stallCount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_skid_barrier #(
        .DATA_WIDTH  (64),
        .CTRL_WIDTH  (3),
        .COUNT_WIDTH (4),
        .ZERO_BUBBLE (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .inData     (inData),
        .inCtrl     (inCtrl),
        .outValid   (outValid),
        .outReady   (outReady),
        .outData    (outData),
        .outCtrl    (outCtrl),
        .occupancy  (occupancy),
        .stallCount (stallCount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [2:0] c);
        inValid = 1'b1;
        inData  = d;
        inCtrl  = c;
        step();
        inValid = 1'b0;
    endtask

    initial begin
        int max_occ;
        rst_n    = 1'b0;
        flush    = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inCtrl   = '0;
        outReady = 1'b0;

        // Reset then single transfer
        step();
        step();
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_outData", outData, 64'd0);
        chk("rst_outCtrl", 64'(outCtrl), 64'd0);
        chk("rst_stall", 64'(stallCount), 64'd0);
        chk("rst_inReady_low", 64'(inReady), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_inReady_high", 64'(inReady), 64'd1);
        outReady = 1'b1;
        push(64'h0000_0005_0000_0003, 3'b101);
        chk("t1_outValid", 64'(outValid), 64'd1);
        chk("t1_outData", outData, 64'h0000_0005_0000_0003);
        chk("t1_outCtrl", 64'(outCtrl), 64'd5);
        chk("t1_occ", 64'(occupancy), 64'd1);
        step();
        chk("t1_drain_valid", 64'(outValid), 64'd0);
        chk("t1_bubble_ctrl", 64'(outCtrl), 64'd0);

        // Back-pressure fill
        outReady = 1'b0;
        push(64'h11, 3'd1);
        chk("bp_occ1", 64'(occupancy), 64'd1);
        chk("bp_stall0", 64'(stallCount), 64'd0);
        push(64'h22, 3'd2);
        chk("bp_occ2", 64'(occupancy), 64'd2);
        chk("bp_inReady", 64'(inReady), 64'd0);
        chk("bp_head", outData, 64'h11);
        chk("bp_head_ctrl", 64'(outCtrl), 64'd1);
        chk("bp_stall1", 64'(stallCount), 64'd1);
        step();
        chk("bp_stall2", 64'(stallCount), 64'd2);
        chk("bp_hold_occ", 64'(occupancy), 64'd2);
        outReady = 1'b1;
        step();
        chk("bp_second", outData, 64'h22);
        chk("bp_second_ctrl", 64'(outCtrl), 64'd2);
        chk("bp_occ_after", 64'(occupancy), 64'd1);
        chk("bp_inReady_back", 64'(inReady), 64'd1);
        step();
        chk("bp_empty", 64'(outValid), 64'd0);
        chk("bp_stall_kept", 64'(stallCount), 64'd2);

        // Full throughput
        max_occ = 0;
        for (int i = 0; i < 100; i++) begin
            inValid = 1'b1;
            inData  = 64'(i);
            inCtrl  = 3'b010;
            step();
            chk("tp_valid", 64'(outValid), 64'd1);
            chk("tp_data", outData, 64'(i));
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        inValid = 1'b0;
        step();
        chk("tp_max_occ", 64'(max_occ), 64'd1);
        chk("tp_drained", 64'(outValid), 64'd0);
        chk("tp_stall", 64'(stallCount), 64'd2);

        // Flush while FULL
        outReady = 1'b0;
        push(64'h44, 3'd3);
        push(64'h55, 3'd4);
        chk("fl_full", 64'(occupancy), 64'd2);
        inValid = 1'b1;
        inData  = 64'h33;
        inCtrl  = 3'd7;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        inValid = 1'b0;
        chk("fl_valid", 64'(outValid), 64'd0);
        chk("fl_occ", 64'(occupancy), 64'd0);
        chk("fl_ctrl", 64'(outCtrl), 64'd0);
        chk("fl_data_kept", outData, 64'h44);
        chk("fl_inReady", 64'(inReady), 64'd1);
        chk("fl_stall", 64'(stallCount), 64'd3);
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_ghost", 64'(outValid), 64'd0);
        end

        // Flush in BUSY drops a same-cycle accept
        outReady = 1'b0;
        push(64'h66, 3'd1);
        inValid = 1'b1;
        inData  = 64'h77;
        inCtrl  = 3'd2;
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        inValid = 1'b0;
        chk("flb_occ", 64'(occupancy), 64'd0);
        chk("flb_data", outData, 64'h66);
        chk("flb_stall", 64'(stallCount), 64'd3);

        // Saturation
        push(64'h88, 3'd1);
        for (int i = 0; i < 20; i++) step();
        chk("sat_15", 64'(stallCount), 64'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_after_flush", 64'(stallCount), 64'd15);
        rst_n = 1'b0;
        step();
        chk("sat_reset", 64'(stallCount), 64'd0);
        rst_n = 1'b1;

        // Reset mid-operation while FULL
        outReady = 1'b0;
        push(64'h99, 3'd5);
        push(64'hAA, 3'd6);
        chk("mr_full", 64'(occupancy), 64'd2);
        outReady = 1'b1;
        rst_n    = 1'b0;
        step();
        chk("mr_valid", 64'(outValid), 64'd0);
        chk("mr_data", outData, 64'd0);
        chk("mr_ctrl", 64'(outCtrl), 64'd0);
        chk("mr_occ", 64'(occupancy), 64'd0);
        chk("mr_inReady", 64'(inReady), 64'd0);
        step();
        chk("mr_inReady_hold", 64'(inReady), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_inReady_up", 64'(inReady), 64'd1);
        step();
        chk("mr_stays_empty", 64'(outValid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
